// File: rtl/uart_rx_sampler_if.sv
// Receive-side bus of uart_rx_sampler: baud tick, serial line, frame
// configuration and the received-byte handshake toward the controller.
interface uart_rx_sampler_if;
  logic       tick16;
  logic       rx;
  logic [1:0] par;
  logic       d_num;
  logic       s_num;
  logic       rd_ack;
  logic [7:0] dout;
  logic       dout_valid;
  logic       data_ready;
  logic [2:0] err;

  modport master (
    output tick16, rx, par, d_num, s_num, rd_ack,
    input  dout, dout_valid, data_ready, err
  );

  modport slave (
    input  tick16, rx, par, d_num, s_num, rd_ack,
    output dout, dout_valid, data_ready, err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: mid-bit sampling of a synchronized serial line,
// runtime frame format (7/8 data, none/even/odd parity, 1/2 stop), error flags.
module uart_rx_sampler #(
  parameter int OVS = 16,
  parameter int MID = 7
) (
  input  logic             clk,
  input  logic             reset,
  uart_rx_sampler_if.slave bus
);

  localparam int            CW      = $clog2(OVS);
  localparam logic [CW-1:0] MID_C   = CW'(MID);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_Z   = {CW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  // Error if the data bits plus the received parity bit break the selected parity.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic       pbit,
                                        input logic       odd);
    logic ones_odd;
    ones_odd     = ^{data, pbit};
    parity_error = odd ? ~ones_odd : ones_odd;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    par_q, par_d;
  logic          dnum_q, dnum_d;
  logic          snum_q, snum_d;
  logic          prev_q, prev_d;
  logic [7:0]    dout_q, dout_d;
  logic [2:0]    err_q, err_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic          sync1_q, sync2_q;

  logic          rx_s;
  logic          mid_s;
  logic          par_en_s;
  logic [2:0]    last_bit_s;
  logic          complete_s;
  logic          stop_err_s;

  assign rx_s       = sync2_q;
  assign mid_s      = (cnt_q == MID_C);
  assign par_en_s   = (par_q == 2'b01) || (par_q == 2'b10);
  assign last_bit_s = dnum_q ? 3'd7 : 3'd6;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame FSM, sampling datapath and output/handshake next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_d      = par_q;
    dnum_d     = dnum_q;
    snum_d     = snum_q;
    prev_d     = prev_q;
    dout_d     = dout_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    ready_d    = ready_q;
    complete_s = 1'b0;
    stop_err_s = 1'b0;

    if (bus.rd_ack) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end

    if (bus.tick16) begin
      prev_d = rx_s;
      cnt_d  = cnt_q + CNT_ONE;
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_Z;
          if (prev_q && !rx_s) begin
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_s) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              bit_d   = 3'd0;
              data_d  = 8'h00;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
              par_d   = bus.par;
              dnum_d  = bus.d_num;
              snum_d  = bus.s_num;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = CNT_Z;
            end
          end else begin
            state_d = ST_START;
          end
        end
        ST_DATA: begin
          if (mid_s) begin
            data_d[bit_q] = rx_s;
            if (bit_q == last_bit_s) begin
              state_d = par_en_s ? ST_PARITY : ST_STOP1;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (mid_s) begin
            perr_d  = parity_error(data_q, rx_s, par_q == 2'b10);
            state_d = ST_STOP1;
          end else begin
            state_d = ST_PARITY;
          end
        end
        ST_STOP1: begin
          if (mid_s) begin
            if (snum_q) begin
              ferr_d  = ~rx_s;
              state_d = ST_STOP2;
            end else begin
              complete_s = 1'b1;
              stop_err_s = ~rx_s;
            end
          end else begin
            state_d = ST_STOP1;
          end
        end
        ST_STOP2: begin
          if (mid_s) begin
            complete_s = 1'b1;
            stop_err_s = ferr_q | ~rx_s;
          end else begin
            state_d = ST_STOP2;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_Z;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // An ack landing on the completion cycle consumes the old byte, so no overrun.
    if (complete_s) begin
      dout_d  = data_q;
      err_d   = {ready_q & ~bus.rd_ack, stop_err_s, perr_q};
      valid_d = 1'b1;
      ready_d = 1'b1;
      state_d = ST_IDLE;
      cnt_d   = CNT_Z;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_Z;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      par_q   <= 2'b00;
      dnum_q  <= 1'b0;
      snum_q  <= 1'b0;
      prev_q  <= 1'b1;
      dout_q  <= 8'h00;
      err_q   <= 3'b000;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      par_q   <= par_d;
      dnum_q  <= dnum_d;
      snum_q  <= snum_d;
      prev_q  <= prev_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.err        = err_q;
  assign bus.dout_valid = valid_q;
  assign bus.data_ready = ready_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames are built from the format rules,
// expected bytes/flags are queued at send time and checked on each dout_valid.
module tb_uart_rx_sampler;
  localparam int OVS    = 16;
  localparam int MID    = 7;
  localparam int TDIV   = 4;
  localparam int BITCLK = OVS * TDIV;
  // Completion edge inside the final stop bit when a frame starts on a tick-aligned clock.
  localparam int ACK_OFS = (TDIV - 1) + TDIV * (MID + 1);

  logic        clk;
  logic        reset;
  int          total;
  int          bad;
  int          ncnt;
  logic        pending;
  logic [10:0] exp_q[$];
  logic [10:0] mon_e;

  uart_rx_sampler_if bus();

  uart_rx_sampler #(.OVS(OVS), .MID(MID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    ncnt       = 0;
    bus.tick16 = 1'b0;
    forever begin
      @(negedge clk);
      ncnt++;
      bus.tick16 = ((ncnt % TDIV) == (TDIV - 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, bus.dout_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", {24'd0, bus.dout}, {24'd0, mon_e[7:0]});
        chk("err", {29'd0, bus.err}, {29'd0, mon_e[10:8]});
        chk("ready_at_valid", {31'd0, bus.data_ready}, 32'd1);
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic align_tick();
    nclk(1);
    while ((ncnt % TDIV) != 0) nclk(1);
  endtask

  task automatic send_bit(input logic b, input int ack_at);
    bus.rx = b;
    for (int i = 0; i < BITCLK; i++) begin
      bus.rd_ack = (i == ack_at);
      nclk(1);
    end
    bus.rd_ack = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic d8, input logic [1:0] pm,
                            input logic pbit, input logic s2, input logic st1,
                            input logic st2, input logic ack_hit);
    logic [7:0] dm;
    logic       pe, perr, ferr, ovr;
    int         nb;
    dm   = d8 ? data : (data & 8'h7F);
    pe   = (pm == 2'b01) || (pm == 2'b10);
    perr = 1'b0;
    if (pm == 2'b01) perr = ^{dm, pbit};
    if (pm == 2'b10) perr = ~(^{dm, pbit});
    ferr = !st1 || (s2 && !st2);
    ovr  = pending && !ack_hit;
    exp_q.push_back({ovr, ferr, perr, dm});
    nb = d8 ? 8 : 7;
    align_tick();
    bus.par   = pm;
    bus.d_num = d8;
    bus.s_num = s2;
    send_bit(1'b0, -1);
    bus.par   = 2'($urandom);
    bus.d_num = 1'($urandom);
    bus.s_num = 1'($urandom);
    for (int i = 0; i < nb; i++) send_bit(data[i], -1);
    if (pe) send_bit(pbit, -1);
    send_bit(st1, (ack_hit && !s2) ? ACK_OFS : -1);
    if (s2) send_bit(st2, ack_hit ? ACK_OFS : -1);
    pending = 1'b1;
  endtask

  task automatic idle_gap(input int bits, input logic do_ack);
    bus.rx = 1'b1;
    if (do_ack) begin
      nclk(4);
      chk("ready_before_ack", {31'd0, bus.data_ready}, {31'd0, pending});
      bus.rd_ack = 1'b1;
      nclk(1);
      bus.rd_ack = 1'b0;
      nclk(1);
      chk("ready_after_ack", {31'd0, bus.data_ready}, 32'd0);
      pending = 1'b0;
      nclk(bits * BITCLK - 6);
    end else begin
      nclk(2);
      chk("ready_hold", {31'd0, bus.data_ready}, {31'd0, pending});
      nclk(bits * BITCLK - 2);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_dout"},  {24'd0, bus.dout}, 32'd0);
    chk({tag, "_err"},   {29'd0, bus.err}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.dout_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, bus.data_ready}, 32'd0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    pending    = 1'b0;
    reset      = 1'b1;
    bus.rx     = 1'b1;
    bus.rd_ack = 1'b0;
    bus.par    = 2'b00;
    bus.d_num  = 1'b1;
    bus.s_num  = 1'b0;
    nclk(5);
    chk_zero_outputs("reset");
    reset = 1'b0;
    nclk(2 * BITCLK);

    send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b1);
    send_frame(8'h41, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b1);
    send_frame(8'h41, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b1);
    send_frame(8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); idle_gap(1, 1'b1);
    send_frame(8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b0);

    align_tick();
    bus.rx = 1'b0;
    nclk(4 * TDIV);
    bus.rx = 1'b1;
    nclk(2 * BITCLK);
    chk("ready_after_glitch", {31'd0, bus.data_ready}, {31'd0, pending});
    idle_gap(1, 1'b1);

    send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b0);
    send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b1);
    send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b0);
    send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); idle_gap(1, 1'b0);

    align_tick();
    bus.par   = 2'b00;
    bus.d_num = 1'b1;
    bus.s_num = 1'b0;
    send_bit(1'b0, -1);
    for (int i = 0; i < 3; i++) send_bit(1'((8'h5A >> i) & 8'h01), -1);
    reset  = 1'b1;
    bus.rx = 1'b1;
    nclk(1);
    chk_zero_outputs("midframe_reset");
    nclk(2);
    reset   = 1'b0;
    pending = 1'b0;
    nclk(2 * BITCLK);
    send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); idle_gap(1, 1'b1);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic [1:0] pm;
      d  = 8'($urandom);
      pm = 2'($urandom_range(0, 3));
      send_frame(d, 1'($urandom), pm, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0));
      idle_gap($urandom_range(1, 2), 1'($urandom));
    end

    nclk(100);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
